// File: rtl/bomberman_pkg.sv
// Shared constants, the flame FSM state type and the flame sprite sequence lookup.
package bomberman_pkg;

  localparam int HACTIVE     = 800;
  localparam int VACTIVE     = 600;
  localparam int SPRITE_SIZE = 32;
  localparam int TRANSPARENT = 137;

  // Number of animation steps in one flame sequence.
  localparam int FLAME_STEPS = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BURN  = 2'd2
  } flame_state_t;

  // Sprite index for each step: grows 0..3 then shrinks back to 0.
  function automatic logic [1:0] flame_sprite(input logic [2:0] step);
    logic [1:0] spr;
    case (step)
      3'd0:    spr = 2'd0;
      3'd1:    spr = 2'd1;
      3'd2:    spr = 2'd2;
      3'd3:    spr = 2'd3;
      3'd4:    spr = 2'd2;
      3'd5:    spr = 2'd1;
      3'd6:    spr = 2'd0;
      default: spr = 2'd0;
    endcase
    return spr;
  endfunction

endpackage

// File: rtl/flame_step_timer.sv
// Frame counter and step index for the flame animation.
// 'step' is the step index that takes effect at the next clock edge, so the
// parent can register its sprite output in the same edge as the tick.
// 'wrap_last' flags the tick that completes the final step.
module flame_step_timer
  import bomberman_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 6
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       load,
  input  logic       tick,
  output logic [2:0] step,
  output logic       wrap_last
);

  localparam logic [5:0] CNT_LAST  = 6'(FRAMES_PER_STEP - 1);
  localparam logic [2:0] STEP_LAST = 3'(FLAME_STEPS - 1);

  logic [5:0] cnt_q, cnt_d;
  logic [2:0] step_q, step_d;

  // Next counter/step: load restarts at step 0, each tick counts a frame and advances on wrap.
  always_comb begin
    cnt_d     = cnt_q;
    step_d    = step_q;
    wrap_last = 1'b0;
    if (load) begin
      cnt_d  = 6'd0;
      step_d = 3'd0;
    end else if (tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = 6'd0;
        if (step_q == STEP_LAST) begin
          step_d    = 3'd0;
          wrap_last = 1'b1;
        end else begin
          step_d = step_q + 3'd1;
        end
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end else begin
      cnt_d  = cnt_q;
      step_d = step_q;
    end
  end

  // Counter and step registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q  <= 6'd0;
      step_q <= 3'd0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

  assign step = step_d;

endmodule

// File: rtl/flame_ctrl.sv
// Flame sequencer for the bomb explosion sprite.
// Optional feature: define FLAME_RETRIGGER_EN to let a valid explode during
// BURN re-latch the position and restart the sequence on the next frame tick.
// All outputs are registered and only move on the edge that samples a
// frame_tick (or reset), so the renderer never sees a mid-frame change.
module flame_ctrl
  import bomberman_pkg::*;
#(
  parameter int                 FRAMES_PER_STEP = 6,
  parameter logic signed [10:0] PARK_POS        = -11'sd64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               explode,
  input  logic signed [10:0] bomb_x,
  input  logic signed [10:0] bomb_y,
  output logic signed [10:0] centerXF,
  output logic signed [10:0] centerYF,
  output logic [1:0]         sprite_num,
  output logic               flame_active,
  output logic               done
);

  // Largest top-left corner that keeps the whole 32x32 cell on screen.
  localparam logic signed [10:0] X_MAX = 11'(HACTIVE - SPRITE_SIZE);
  localparam logic signed [10:0] Y_MAX = 11'(VACTIVE - SPRITE_SIZE);

  flame_state_t       state_q, state_d;
  logic signed [10:0] lat_x_q, lat_x_d;
  logic signed [10:0] lat_y_q, lat_y_d;
  logic signed [10:0] center_x_q, center_x_d;
  logic signed [10:0] center_y_q, center_y_d;
  logic [1:0]         sprite_q, sprite_d;
  logic               active_q, active_d;
  logic               done_q, done_d;

  logic               req_ok_s;
  logic               retrig_s;
  logic               tmr_load_s;
  logic               tmr_tick_s;
  logic [2:0]         step_s;
  logic               wrap_last_s;

  assign req_ok_s = explode
                    && (bomb_x >= 11'sd0) && (bomb_x <= X_MAX)
                    && (bomb_y >= 11'sd0) && (bomb_y <= Y_MAX);

`ifdef FLAME_RETRIGGER_EN
  assign retrig_s = req_ok_s && (state_q == BURN);
`else
  assign retrig_s = 1'b0;
`endif

  // A re-trigger takes priority over a same-cycle tick so the old sequence cannot finish.
  assign tmr_load_s = (state_q == ARMED) && frame_tick;
  assign tmr_tick_s = (state_q == BURN) && frame_tick && !retrig_s;

  flame_step_timer #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_timer (
    .clk      (clk),
    .clear    (reset),
    .load     (tmr_load_s),
    .tick     (tmr_tick_s),
    .step     (step_s),
    .wrap_last(wrap_last_s)
  );

  // Next-state and next-output logic; outputs hold unless a tick moves the sequence.
  always_comb begin
    state_d    = state_q;
    lat_x_d    = lat_x_q;
    lat_y_d    = lat_y_q;
    center_x_d = center_x_q;
    center_y_d = center_y_q;
    sprite_d   = sprite_q;
    active_d   = active_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_ok_s) begin
          lat_x_d = bomb_x;
          lat_y_d = bomb_y;
          state_d = ARMED;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (frame_tick) begin
          state_d    = BURN;
          center_x_d = lat_x_q;
          center_y_d = lat_y_q;
          sprite_d   = 2'd0;
          active_d   = 1'b1;
        end else begin
          state_d = ARMED;
        end
      end
      BURN: begin
        if (retrig_s) begin
          lat_x_d = bomb_x;
          lat_y_d = bomb_y;
          state_d = ARMED;
        end else if (frame_tick) begin
          if (wrap_last_s) begin
            state_d    = IDLE;
            center_x_d = PARK_POS;
            center_y_d = PARK_POS;
            sprite_d   = 2'd0;
            active_d   = 1'b0;
            done_d     = 1'b1;
          end else begin
            sprite_d = flame_sprite(step_s);
          end
        end else begin
          state_d = BURN;
        end
      end
      default: begin
        state_d    = IDLE;
        center_x_d = PARK_POS;
        center_y_d = PARK_POS;
        sprite_d   = 2'd0;
        active_d   = 1'b0;
      end
    endcase
  end

  // State, latched position and output registers; reset parks the sprite and drops the latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_x_q    <= 11'sd0;
      lat_y_q    <= 11'sd0;
      center_x_q <= PARK_POS;
      center_y_q <= PARK_POS;
      sprite_q   <= 2'd0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_x_q    <= lat_x_d;
      lat_y_q    <= lat_y_d;
      center_x_q <= center_x_d;
      center_y_q <= center_y_d;
      sprite_q   <= sprite_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign centerXF     = center_x_q;
  assign centerYF     = center_y_q;
  assign sprite_num   = sprite_q;
  assign flame_active = active_q;
  assign done         = done_q;

endmodule

// File: tb/tb_flame_ctrl.sv
// Scoreboard bench for flame_ctrl: dut_a uses FRAMES_PER_STEP=2, dut_b uses 1.
// Every frame_tick or reset pushes the expected post-edge outputs of both DUTs;
// the monitor pops on that edge and otherwise requires outputs to stay put.
module tb_flame_ctrl;

  typedef struct packed {
    logic               active;
    logic [1:0]         sprite;
    logic signed [10:0] cx;
    logic signed [10:0] cy;
    logic               done;
  } obs_t;

  localparam logic signed [10:0] PARK = -11'sd64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, frame_tick, explode_a, explode_b;
  logic signed [10:0] bomb_x, bomb_y;
  logic signed [10:0] cx_a, cy_a, cx_b, cy_b;
  logic [1:0]         sprite_a, sprite_b;
  logic               active_a, active_b, done_a, done_b;

  flame_ctrl #(.FRAMES_PER_STEP(2)) dut_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .explode(explode_a),
    .bomb_x(bomb_x), .bomb_y(bomb_y), .centerXF(cx_a), .centerYF(cy_a),
    .sprite_num(sprite_a), .flame_active(active_a), .done(done_a)
  );

  flame_ctrl #(.FRAMES_PER_STEP(1)) dut_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .explode(explode_b),
    .bomb_x(bomb_x), .bomb_y(bomb_y), .centerXF(cx_b), .centerYF(cy_b),
    .sprite_num(sprite_b), .flame_active(active_b), .done(done_b)
  );

  obs_t act_a, act_b;
  assign act_a = {active_a, sprite_a, cx_a, cy_a, done_a};
  assign act_b = {active_b, sprite_b, cx_b, cy_b, done_b};

  obs_t qa[$];
  obs_t qb[$];
  obs_t cur_a, cur_b;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic ev_q     = 1'b0;

  // Hand-written sprite sequences after each tick from BURN entry.
  logic [1:0] seq2 [14] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3,
                            2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};
  logic [1:0] seq1 [7]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};

  function automatic obs_t park(input logic d);
    obs_t o;
    o.active = 1'b0; o.sprite = 2'd0; o.cx = PARK; o.cy = PARK; o.done = d;
    return o;
  endfunction

  function automatic obs_t burn(input logic [1:0] s, input logic signed [10:0] x,
                                input logic signed [10:0] y);
    obs_t o;
    o.active = 1'b1; o.sprite = s; o.cx = x; o.cy = y; o.done = 1'b0;
    return o;
  endfunction

  task automatic check(input string nm, input obs_t act, input obs_t ex);
    n_checks++;
    if (act === ex) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0t: got active=%0b sprite=%0d x=%0d y=%0d done=%0b, expected active=%0b sprite=%0d x=%0d y=%0d done=%0b",
               nm, $time, act.active, act.sprite, act.cx, act.cy, act.done,
               ex.active, ex.sprite, ex.cx, ex.cy, ex.done);
    end
  endtask

  // Output-event marker: the edge that sampled a tick or a reset.
  always @(posedge clk) ev_q <= frame_tick | reset;

  // Monitor: pop on output events, otherwise require unchanged outputs and done low.
  initial begin
    logic on;
    on = 1'b0;
    forever begin
      @(negedge clk);
      if (ev_q) begin
        on = 1'b1;
        if (qa.size() > 0) cur_a = qa.pop_front();
        else begin n_checks++; $display("FAIL dut_a_queue: got output event, expected none queued"); end
        if (qb.size() > 0) cur_b = qb.pop_front();
        else begin n_checks++; $display("FAIL dut_b_queue: got output event, expected none queued"); end
      end else begin
        cur_a.done = 1'b0;
        cur_b.done = 1'b0;
      end
      if (on) begin
        check("dut_a", act_a, cur_a);
        check("dut_b", act_b, cur_b);
      end
    end
  end

  task automatic drive(input logic t, input logic ea, input logic eb,
                       input logic signed [10:0] x, input logic signed [10:0] y,
                       input logic r, input obs_t xa, input obs_t xb);
    frame_tick = t; explode_a = ea; explode_b = eb; bomb_x = x; bomb_y = y; reset = r;
    if (t || r) begin
      qa.push_back(xa);
      qb.push_back(xb);
    end
    @(posedge clk); #2;
    frame_tick = 1'b0; explode_a = 1'b0; explode_b = 1'b0; reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic tick(input obs_t xa, input obs_t xb);
    drive(1'b1, 1'b0, 1'b0, 11'sd0, 11'sd0, 1'b0, xa, xb);
  endtask

  task automatic boom_a(input logic signed [10:0] x, input logic signed [10:0] y);
    drive(1'b0, 1'b1, 1'b0, x, y, 1'b0, park(1'b0), park(1'b0));
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 11'sd0, 11'sd0, 1'b1, park(1'b0), park(1'b0));
  endtask

  initial begin
    obs_t p0;
    p0 = park(1'b0);
    reset = 1'b0; frame_tick = 1'b0; explode_a = 1'b0; explode_b = 1'b0;
    bomb_x = 11'sd0; bomb_y = 11'sd0;
    @(posedge clk); #2;

    // Reset state
    do_reset();

    // Basic run at (100,200): 14 ticks of animation, then the closing tick
    boom_a(11'sd100, 11'sd200);
    for (int i = 0; i < 14; i++) tick(burn(seq2[i], 11'sd100, 11'sd200), p0);
    tick(park(1'b1), p0);

    // Out-of-range requests are ignored
    boom_a(11'sd769, 11'sd10);
    repeat (20) tick(p0, p0);
    boom_a(11'sd0, 11'sd569);
    repeat (3) tick(p0, p0);
    boom_a(-11'sd1, 11'sd5);
    repeat (2) tick(p0, p0);

    // Same-cycle tick does not count; boundary corner (768,568) is accepted
    drive(1'b1, 1'b1, 1'b0, 11'sd768, 11'sd568, 1'b0, p0, p0);
    tick(burn(2'd0, 11'sd768, 11'sd568), p0);
    tick(burn(2'd0, 11'sd768, 11'sd568), p0);
    do_reset();

    // Explode while ARMED is ignored
    boom_a(11'sd10, 11'sd10);
    boom_a(11'sd500, 11'sd500);
    tick(burn(2'd0, 11'sd10, 11'sd10), p0);
    do_reset();

    // Mid-burn reset at step 3: parked, and no done afterwards
    boom_a(11'sd40, 11'sd50);
    for (int i = 0; i < 7; i++) tick(burn(seq2[i], 11'sd40, 11'sd50), p0);
    do_reset();
    repeat (16) tick(p0, p0);

    // Explode at step 4
    boom_a(11'sd100, 11'sd100);
    for (int i = 0; i < 9; i++) tick(burn(seq2[i], 11'sd100, 11'sd100), p0);
    boom_a(11'sd300, 11'sd300);
`ifdef FLAME_RETRIGGER_EN
    for (int i = 0; i < 14; i++) tick(burn(seq2[i], 11'sd300, 11'sd300), p0);
`else
    for (int i = 9; i < 14; i++) tick(burn(seq2[i], 11'sd100, 11'sd100), p0);
`endif
    tick(park(1'b1), p0);

    // FRAMES_PER_STEP=1: done on the 7th tick after BURN entry
    drive(1'b0, 1'b0, 1'b1, 11'sd64, 11'sd32, 1'b0, p0, p0);
    for (int i = 0; i < 7; i++) tick(p0, burn(seq1[i], 11'sd64, 11'sd32));
    tick(p0, park(1'b1));

    repeat (3) @(posedge clk);
    n_checks++;
    if (qa.size() == 0 && qb.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got %0d/%0d entries left, expected 0/0", qa.size(), qb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
